rec_fn32_to_rec_fn64_pipe: RTL and testbench
============================================

// Module: rec_fn32_to_rec_fn64_pipe
// PURPOSE
// - Widening converter: HardFloat recoded binary32 (33b) -> recoded binary64 (65b); inverse direction of the
//   recoded f64->f32 narrowing path. Sits in the FPU convert unit, fed by the f32 result bus.
// - Exact conversion: no rounding. Only exception raised is invalid for signaling NaN.
// - 2-stage valid/ready pipeline, full throughput, backpressure from downstream.
// PARAMETERS
// - TAG_W  5  width of opaque tag carried alongside each operand (e.g. dest reg id)
// PORTS
// - clock              in   1      single clock; all state updates on rising edge
// - reset              in   1      synchronous, active-high
// - io_in_valid        in   1      operand present
// - io_in_ready        out  1      block accepts operand this cycle
// - io_in_bits_in      in   33     recoded f32: [32]=sign, [31:23]=exp, [22:0]=fract
// - io_in_bits_tag     in   TAG_W  passed through unchanged
// - io_out_valid       out  1      result present
// - io_out_ready       in   1      consumer accepts result this cycle
// - io_out_bits_out    out  65     recoded f64: [64]=sign, [63:52]=exp, [51:0]=fract
// - io_out_bits_flags  out  5      {invalid, infinite, overflow, underflow, inexact}
// - io_out_bits_tag    out  TAG_W  tag of this result
// BEHAVIOUR
// - Reset: s1_valid=s2_valid=0; io_out_valid=0; io_in_ready=1; out bits/flags/tag regs cleared to 0.
// - Transfer occurs on valid&ready at a clock edge. Latency: accepted in cycle N -> io_out_valid in N+2 if no stall.
// - Stage 1 (decode): register sign, class {isZero=exp[8:6]==0, isInf=exp[8:7]==3&~exp[6],
//   isNaN=exp[8:7]==3&exp[6]}, exp[8:0], fract[22:0], tag.
// - Stage 2 (encode), registered into output regs:
//   zero -> {sign, 12'h000, 52'h0}; inf -> {sign, 12'hC00, 52'h0}.
//   NaN  -> canonical {1'b0, 12'hE00, 1'b1, 51'h0} = 65'h0_E008_0000_0000_0000.
//   else -> {sign, {3'b0,exp}+12'd1792, fract,29'h0}. The 12b add never overflows; there is no subnormal
//   special case (recoded f32 subnormals are already normalized).
// - flags: invalid(bit4)=isNaN & ~fract[22] (sNaN); bits[3:0] always 0.
// - Handshake: s2_adv = ~s2_valid | io_out_ready; s1_adv = ~s1_valid | s2_adv; io_in_ready = s1_adv.
//   s1 loads on io_in_valid&io_in_ready; s2 loads from s1 when s1_valid&s2_adv.
//   A stage that advances with no incoming data clears its valid.
// - io_in_ready is combinational from io_out_ready (no skid). Stall with both stages full -> io_in_ready=0;
//   out bits/tag held stable while io_out_valid&~io_out_ready.
// - Simultaneous accept and emit with both stages full and io_out_ready=1: all three move in one cycle; no bubble.
// - Reset mid-operation discards in-flight operands; no output is produced for them.
// - No combinational path from io_in_* to io_out_*.
// STRUCTURE
// - Package fpu_rec_pkg: REC32_W=33, REC64_W=65, EXP_ADJ_32_64=12'd1792, REC64_CANON_NAN, flag bit indices.
// - Sub-module rec_fn32_to_rec_fn64_core: combinational stage-2 encode (class+fields -> out, flags).
//   The pipe wraps it with the two register stages and the handshake.
// TESTING
// - 1.0f in=33'h0_8000_0000, ready=1 -> 2 cycles later out=65'h0_8000_0000_0000_0000, flags=0, tag echoed.
// - -0.0 in=33'h1_0000_0000 -> out=65'h1_0000_0000_0000_0000; +inf in=33'h0_C000_0000 ->
//   out=65'h0_C000_0000_0000_0000; flags=0 for both.
// - sNaN in=33'h0_E000_0001 -> out=canonical NaN, flags=5'h10; qNaN in=33'h1_E040_0000 -> canonical NaN, flags=0.
// - Backpressure: stream 4 tagged ops, io_out_ready=0 for 3 cycles -> io_in_ready=0 once 2 are held;
//   all 4 delivered in order; none dropped or duplicated.
// - Throughput: io_out_ready=1, 100 random back-to-back ops -> one result per cycle after 2-cycle fill;
//   each result matches the reference model.
// - Reset asserted with both stages full -> next cycle io_out_valid=0, io_in_ready=1; no stale output afterwards.

Source files
------------

// File: rtl/fpu_rec_pkg.sv
// Shared constants and decode helpers for the recoded-float convert unit.
// Recoded formats follow HardFloat: {sign, exp, fract} with a 3-bit class code in the exponent MSBs.
package fpu_rec_pkg;

  localparam int REC32_W = 33;
  localparam int REC64_W = 65;
  localparam int FLAG_W  = 5;

  localparam logic [11:0]        EXP_ADJ_32_64   = 12'd1792;
  localparam logic [REC64_W-1:0] REC64_CANON_NAN = 65'h0_E008_0000_0000_0000;

  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_INFINITE  = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  typedef struct packed {
    logic is_zero;
    logic is_inf;
    logic is_nan;
  } rec_class_t;

  function automatic rec_class_t classify32(input logic [8:0] exp);
    rec_class_t c;
    c.is_zero = (exp[8:6] == 3'b000);
    c.is_inf  = (exp[8:7] == 2'b11) & ~exp[6];
    c.is_nan  = (exp[8:7] == 2'b11) &  exp[6];
    return c;
  endfunction

endpackage

// File: rtl/rec_fn32_to_rec_fn64_core.sv
// Combinational encode of a decoded recoded-f32 operand into recoded f64 plus exception flags.
module rec_fn32_to_rec_fn64_core
  import fpu_rec_pkg::*;
(
  input  logic               sign_i,
  input  rec_class_t         cls_i,
  input  logic [8:0]         exp_i,
  input  logic [22:0]        fract_i,
  output logic [REC64_W-1:0] out_o,
  output logic [FLAG_W-1:0]  flags_o
);

  // Special classes first; normal and already-normalized subnormal values just rebias the exponent.
  always_comb begin
    out_o   = {REC64_W{1'b0}};
    flags_o = {FLAG_W{1'b0}};
    if (cls_i.is_nan) begin
      out_o                 = REC64_CANON_NAN;
      flags_o[FLAG_INVALID] = ~fract_i[22];
    end else if (cls_i.is_inf) begin
      out_o = {sign_i, 12'hC00, 52'h0};
    end else if (cls_i.is_zero) begin
      out_o = {sign_i, 12'h000, 52'h0};
    end else begin
      out_o = {sign_i, {3'b000, exp_i} + EXP_ADJ_32_64, fract_i, 29'h0};
    end
  end

endmodule

// File: rtl/rec_fn32_to_rec_fn64_pipe.sv
// Two-stage valid/ready pipeline widening recoded f32 to recoded f64 (exact, sNaN -> invalid).
// Stage 1 registers the decoded operand, stage 2 registers the encoded result and flags.
module rec_fn32_to_rec_fn64_pipe
  import fpu_rec_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_in_valid,
  output logic               io_in_ready,
  input  logic [REC32_W-1:0] io_in_bits_in,
  input  logic [TAG_W-1:0]   io_in_bits_tag,
  output logic               io_out_valid,
  input  logic               io_out_ready,
  output logic [REC64_W-1:0] io_out_bits_out,
  output logic [FLAG_W-1:0]  io_out_bits_flags,
  output logic [TAG_W-1:0]   io_out_bits_tag
);

  logic               s1_valid_q, s1_valid_d;
  logic               s1_sign_q,  s1_sign_d;
  rec_class_t         s1_cls_q,   s1_cls_d;
  logic [8:0]         s1_exp_q,   s1_exp_d;
  logic [22:0]        s1_fract_q, s1_fract_d;
  logic [TAG_W-1:0]   s1_tag_q,   s1_tag_d;
  logic               s2_valid_q, s2_valid_d;
  logic [REC64_W-1:0] out_q,      out_d;
  logic [FLAG_W-1:0]  flags_q,    flags_d;
  logic [TAG_W-1:0]   tag_q,      tag_d;

  logic               s2_adv_s, s1_adv_s, s1_load_s, s2_load_s;
  logic [REC64_W-1:0] enc_out_s;
  logic [FLAG_W-1:0]  enc_flags_s;

  assign s2_adv_s  = ~s2_valid_q | io_out_ready;
  assign s1_adv_s  = ~s1_valid_q | s2_adv_s;
  assign s1_load_s = io_in_valid & s1_adv_s;
  assign s2_load_s = s1_valid_q & s2_adv_s;

  assign io_in_ready       = s1_adv_s;
  assign io_out_valid      = s2_valid_q;
  assign io_out_bits_out   = out_q;
  assign io_out_bits_flags = flags_q;
  assign io_out_bits_tag   = tag_q;

  rec_fn32_to_rec_fn64_core u_core (
    .sign_i  (s1_sign_q),
    .cls_i   (s1_cls_q),
    .exp_i   (s1_exp_q),
    .fract_i (s1_fract_q),
    .out_o   (enc_out_s),
    .flags_o (enc_flags_s)
  );

  // Next-state: an advancing stage takes its upstream valid (clearing when empty); data loads only on a real transfer.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_cls_d   = s1_cls_q;
    s1_exp_d   = s1_exp_q;
    s1_fract_d = s1_fract_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    out_d      = out_q;
    flags_d    = flags_q;
    tag_d      = tag_q;
    if (s1_adv_s) begin
      s1_valid_d = io_in_valid;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (s1_load_s) begin
      s1_sign_d  = io_in_bits_in[32];
      s1_cls_d   = classify32(io_in_bits_in[31:23]);
      s1_exp_d   = io_in_bits_in[31:23];
      s1_fract_d = io_in_bits_in[22:0];
      s1_tag_d   = io_in_bits_tag;
    end else begin
      s1_tag_d   = s1_tag_q;
    end
    if (s2_adv_s) begin
      s2_valid_d = s1_valid_q;
    end else begin
      s2_valid_d = s2_valid_q;
    end
    if (s2_load_s) begin
      out_d   = enc_out_s;
      flags_d = enc_flags_s;
      tag_d   = s1_tag_q;
    end else begin
      tag_d   = tag_q;
    end
  end

  // State registers with synchronous reset discarding any in-flight operands.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_cls_q   <= '0;
      s1_exp_q   <= 9'h000;
      s1_fract_q <= 23'h0;
      s1_tag_q   <= {TAG_W{1'b0}};
      s2_valid_q <= 1'b0;
      out_q      <= {REC64_W{1'b0}};
      flags_q    <= {FLAG_W{1'b0}};
      tag_q      <= {TAG_W{1'b0}};
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_cls_q   <= s1_cls_d;
      s1_exp_q   <= s1_exp_d;
      s1_fract_q <= s1_fract_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      out_q      <= out_d;
      flags_q    <= flags_d;
      tag_q      <= tag_d;
    end
  end

endmodule

// File: tb/tb_rec_fn32_to_rec_fn64_pipe.sv
// Directed-vector and scoreboard bench for the recoded f32 -> f64 widening pipeline.
module tb_rec_fn32_to_rec_fn64_pipe;

  localparam int TAG_W = 5;

  logic              clock;
  logic              reset;
  logic              io_in_valid;
  logic              io_in_ready;
  logic [32:0]       io_in_bits_in;
  logic [TAG_W-1:0]  io_in_bits_tag;
  logic              io_out_valid;
  logic              io_out_ready;
  logic [64:0]       io_out_bits_out;
  logic [4:0]        io_out_bits_flags;
  logic [TAG_W-1:0]  io_out_bits_tag;

  rec_fn32_to_rec_fn64_pipe #(.TAG_W(TAG_W)) dut (
    .clock             (clock),
    .reset             (reset),
    .io_in_valid       (io_in_valid),
    .io_in_ready       (io_in_ready),
    .io_in_bits_in     (io_in_bits_in),
    .io_in_bits_tag    (io_in_bits_tag),
    .io_out_valid      (io_out_valid),
    .io_out_ready      (io_out_ready),
    .io_out_bits_out   (io_out_bits_out),
    .io_out_bits_flags (io_out_bits_flags),
    .io_out_bits_tag   (io_out_bits_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string            name;
    logic [32:0]      in;
    logic [TAG_W-1:0] tag;
    logic [64:0]      out;
    logic [4:0]       flags;
  } vec_t;

  typedef struct {
    logic [64:0]      out;
    logic [4:0]       flags;
    logic [TAG_W-1:0] tag;
  } res_t;

  localparam logic [64:0] CANON_NAN = 65'h0_E008_0000_0000_0000;

  vec_t        vecs [12];
  res_t        sb_q [$];
  int          total = 0;
  int          bad   = 0;
  int          delivered = 0;
  logic        stall_prev = 1'b0;
  res_t        held_prev;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [32:0] x, input logic [TAG_W-1:0] tag);
    res_t        r;
    logic [8:0]  e;
    e       = x[31:23];
    r.tag   = tag;
    r.flags = 5'h00;
    if (e[8:6] == 3'b000) r.out = {x[32], 64'h0};
    else if (e[8:6] == 3'b110) r.out = {x[32], 12'hC00, 52'h0};
    else if (e[8:6] == 3'b111) begin
      r.out   = CANON_NAN;
      r.flags = x[22] ? 5'h00 : 5'h10;
    end
    else r.out = {x[32], 12'(e) + 12'd1792, x[22:0], 29'h0};
    return r;
  endfunction

  // Called just after a negedge with inputs driven; scores this cycle's transfers, returns at the next negedge.
  task automatic cycle_sample(output logic fired_in);
    res_t exp_r;
    res_t act_r;
    #1;
    act_r.out   = io_out_bits_out;
    act_r.flags = io_out_bits_flags;
    act_r.tag   = io_out_bits_tag;
    if (stall_prev && io_out_valid) check("hold_stable", {act_r.out, act_r.tag}, {held_prev.out, held_prev.tag});
    if (io_out_valid && io_out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out", 128'(io_out_valid), 128'(0));
      end else begin
        exp_r = sb_q.pop_front();
        check("stream_result", {act_r.out, act_r.flags, act_r.tag}, {exp_r.out, exp_r.flags, exp_r.tag});
        delivered++;
      end
    end
    fired_in = io_in_valid & io_in_ready;
    if (fired_in) sb_q.push_back(model(io_in_bits_in, io_in_bits_tag));
    stall_prev = io_out_valid & ~io_out_ready;
    held_prev  = act_r;
    @(negedge clock);
  endtask

  initial begin
    logic        fi;
    int          idx;
    logic [32:0] ops [4];

    vecs[0]  = '{"one",       33'h0_8000_0000, 5'd1,  65'h0_8000_0000_0000_0000, 5'h00};
    vecs[1]  = '{"neg_zero",  33'h1_0000_0000, 5'd2,  65'h1_0000_0000_0000_0000, 5'h00};
    vecs[2]  = '{"pos_inf",   33'h0_C000_0000, 5'd3,  65'h0_C000_0000_0000_0000, 5'h00};
    vecs[3]  = '{"snan",      33'h0_E000_0001, 5'd4,  CANON_NAN,                 5'h10};
    vecs[4]  = '{"qnan",      33'h1_E040_0000, 5'd5,  CANON_NAN,                 5'h00};
    vecs[5]  = '{"neg_inf",   33'h1_C000_0000, 5'd6,  65'h1_C000_0000_0000_0000, 5'h00};
    vecs[6]  = '{"zero_junk", 33'h0_1F81_2345, 5'd7,  65'h0_0000_0000_0000_0000, 5'h00};
    vecs[7]  = '{"two",       33'h0_8080_0000, 5'd8,  65'h0_8010_0000_0000_0000, 5'h00};
    vecs[8]  = '{"one_half",  33'h0_8040_0000, 5'd9,  65'h0_8008_0000_0000_0000, 5'h00};
    vecs[9]  = '{"min_sub",   33'h0_3580_0000, 5'd10, 65'h0_76B0_0000_0000_0000, 5'h00};
    vecs[10] = '{"neg_max",   33'h1_BFFF_FFFF, 5'd11, 65'h1_87FF_FFFF_E000_0000, 5'h00};
    vecs[11] = '{"snan_zero", 33'h1_E000_0000, 5'd31, CANON_NAN,                 5'h10};

    reset          = 1'b1;
    io_in_valid    = 1'b0;
    io_in_bits_in  = 33'h0;
    io_in_bits_tag = 5'd0;
    io_out_ready   = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("rst_out_valid", 128'(io_out_valid), 128'(0));
    check("rst_in_ready",  128'(io_in_ready),  128'(1));
    check("rst_out_bits",  128'({io_out_bits_out, io_out_bits_flags, io_out_bits_tag}), 128'(0));

    // Directed vectors: two-edge latency, then value/flags/tag.
    for (int i = 0; i < 12; i++) begin
      io_in_valid    = 1'b1;
      io_in_bits_in  = vecs[i].in;
      io_in_bits_tag = vecs[i].tag;
      @(posedge clock);
      @(negedge clock);
      io_in_valid = 1'b0;
      check({"lat1_", vecs[i].name}, 128'(io_out_valid), 128'(0));
      @(posedge clock);
      @(negedge clock);
      check({"valid_", vecs[i].name}, 128'(io_out_valid), 128'(1));
      check({"out_", vecs[i].name},   128'(io_out_bits_out),   128'(vecs[i].out));
      check({"flags_", vecs[i].name}, 128'(io_out_bits_flags), 128'(vecs[i].flags));
      check({"tag_", vecs[i].name},   128'(io_out_bits_tag),   128'(vecs[i].tag));
    end
    @(posedge clock);
    @(negedge clock);
    check("drained", 128'(io_out_valid), 128'(0));

    // Backpressure: 4 tagged ops, consumer stalls the first 3 cycles.
    ops[0] = 33'h0_8000_0000; ops[1] = 33'h0_E000_0001;
    ops[2] = 33'h1_8123_4567; ops[3] = 33'h0_C000_0000;
    idx = 0;
    delivered = 0;
    for (int c = 0; c < 40; c++) begin
      io_out_ready   = (c >= 3);
      io_in_valid    = (idx < 4);
      io_in_bits_in  = ops[idx % 4];
      io_in_bits_tag = 5'(20 + idx);
      if (c == 2) begin
        #1;
        check("bp_in_ready_low", 128'(io_in_ready), 128'(0));
      end
      cycle_sample(fi);
      if (fi) idx++;
      if (idx == 4 && delivered == 4) break;
    end
    io_in_valid = 1'b0;
    check("bp_accepted",  128'(idx),       128'(4));
    check("bp_delivered", 128'(delivered), 128'(4));
    check("bp_sb_empty",  128'(sb_q.size()), 128'(0));

    // Throughput: back-to-back random ops, one result per cycle after a 2-cycle fill.
    io_out_ready = 1'b1;
    delivered = 0;
    for (int c = 0; c < 100; c++) begin
      io_in_valid    = 1'b1;
      io_in_bits_in  = {1'($urandom), 32'($urandom)};
      io_in_bits_tag = 5'($urandom);
      #1;
      check("tp_ready_valid", 128'({io_in_ready, io_out_valid}), 128'({1'b1, c >= 2}));
      cycle_sample(fi);
    end
    io_in_valid = 1'b0;
    for (int c = 0; c < 10; c++) cycle_sample(fi);
    check("tp_delivered", 128'(delivered), 128'(100));
    check("tp_sb_empty",  128'(sb_q.size()), 128'(0));

    // Reset with both stages full: in-flight ops are discarded.
    io_out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      io_in_valid    = 1'b1;
      io_in_bits_in  = 33'h0_8080_0000;
      io_in_bits_tag = 5'(c + 1);
      cycle_sample(fi);
    end
    io_in_valid = 1'b0;
    check("full_before_rst", 128'({io_out_valid, io_in_ready}), 128'({1'b1, 1'b0}));
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("rst_mid_valid", 128'(io_out_valid), 128'(0));
    check("rst_mid_ready", 128'(io_in_ready),  128'(1));
    @(negedge clock);
    reset = 1'b0;
    sb_q.delete();
    stall_prev   = 1'b0;
    io_out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      check("no_stale_out", 128'(io_out_valid), 128'(0));
      cycle_sample(fi);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
